factory_press_accumulator: RTL and testbench
============================================

# factory_press_accumulator

Collects per-machine minimum button-press results from the `CORE_COUNT` solver cores and sums them into the Day 10 total. It sits downstream of the factory machine initializer and its cores, and upstream of the SPI master's transmit path. Once `MACHINE_COUNT` results are summed, it hands the 16-bit total to the SPI transmit path as two bytes, MSB first.

## Interface

Parameters:
- `CORE_COUNT`, 2: number of solver cores feeding results.
- `MACHINE_COUNT`, 200: results to accumulate before transmitting.
- `PRESS_WIDTH`, 4: width of one per-machine press count (covers `MAX_BUTTON_COUNT` = 13).
- `TOTAL_WIDTH`, 16: accumulator width; fixed at 16 for two-byte transmit.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; clears the accumulator and arms collection.
- `core_result_valid`  in  `CORE_COUNT`  per-core result valid.
- `core_result_presses`  in  `CORE_COUNT*PRESS_WIDTH`  per-core press count; core i occupies bits `[i*PRESS_WIDTH +: PRESS_WIDTH]`.
- `core_result_ready`  out  `CORE_COUNT`  per-core accept; one-hot or zero.
- `tx_byte`  out  8  byte offered to the SPI transmit path.
- `tx_valid`  out  1  `tx_byte` is valid.
- `tx_ready`  in  1  SPI transmit path accepts `tx_byte`.
- `total`  out  `TOTAL_WIDTH`  running or final sum.
- `overflow`  out  1  sticky; the sum saturated.
- `done`  out  1  both bytes have been transmitted.

## Operation

- States: IDLE, COLLECT, SEND_HI, SEND_LO, DONE.
- **Reset** (any time, including mid-operation): go to IDLE.
  - `total`=0, `overflow`=0, `done`=0, `tx_valid`=0, `tx_byte`=0, `core_result_ready`=0.
  - Result counter = 0; round-robin pointer = 0.
- **IDLE:**
  - `start` clears `total`, `overflow`, counter and pointer, then moves to COLLECT.
  - All other inputs are ignored.
- **COLLECT:**
  - Round-robin grant: starting at the pointer, pick the first core with `core_result_valid` set.
  - `core_result_ready[g]` is driven combinationally high for the granted core only. At most one result is accepted per cycle.
  - On accept:
    - `total` ← `total` + zero-extended presses, saturating at 0xFFFF.
    - If the add would exceed 0xFFFF, set `overflow`.
    - Increment the counter.
    - Pointer ← (g+1) mod `CORE_COUNT`.
  - With no valid core, the pointer holds.
  - When an accept brings the counter to `MACHINE_COUNT`, the next state is SEND_HI. No ready is asserted after that.
- **SEND_HI:**
  - `tx_valid`=1, `tx_byte`=`total[15:8]`.
  - On `tx_valid`&`tx_ready`, go to SEND_LO.
- **SEND_LO:**
  - `tx_valid`=1, `tx_byte`=`total[7:0]`.
  - On handshake, go to DONE.
- **DONE:**
  - `done`=1 and `tx_valid`=0; `total` holds.
  - `start` behaves as in IDLE: clears the sum and enters COLLECT, and `done` deasserts.
- **`start` outside IDLE/DONE:** ignored; the run is not restarted.
- **Transmit handshake:**
  - `tx_byte` is stable while `tx_valid` is high and `tx_ready` is low.
  - `tx_valid` never drops without a handshake, except on reset.
- **Core-side handshake:** a core holds valid and data until it sees ready. The block never accepts a result on a cycle where that core's valid is low.

## Timing

- Result accepted at edge N: `total` and the counter are updated at edge N (visible after N).
- Last accept at edge N: state is SEND_HI after N, so `tx_valid` is high in cycle N+1.
- Byte handshakes:
  - Hi byte handshake at edge M: lo byte is presented from M onward.
  - Lo byte handshake at edge K: `done`=1 after K.
- Minimum total time from `start` to `done` with `tx_ready` tied high: `MACHINE_COUNT` + 3 cycles.
- Throughput is one result per cycle, regardless of how many cores are valid.
- `core_result_ready` is combinational from state, pointer and valids. No combinational path runs from `tx_ready` to `tx_valid`.

## Test plan

- **Reset values:** hold `reset_n` low → all outputs 0. Release, pulse `start` → state COLLECT with `total`=0.
- **Single core:** `MACHINE_COUNT`=4; core0 supplies 3,5,7,1 back-to-back; `tx_ready`=1 → bytes 0x00 then 0x10; `done`=1 at `start`+7 cycles; `total`=16.
- **Round-robin fairness:** both cores hold valid continuously (core0=2, core1=9) for 6 accepts → grants alternate 0,1,0,1,0,1; `total`=33.
- **Transmit backpressure:** `tx_ready` held low for 5 cycles in SEND_HI → `tx_byte`=`total[15:8]` stable and `tx_valid` held. Raise `tx_ready` → lo byte on the next cycle.
- **Saturation:** `MACHINE_COUNT`=200, `TOTAL_WIDTH`=16. Preload via 200 results of 13 → `total`=2600, no overflow. Force `TOTAL_WIDTH` path with a 12-bit test build variant at value 4090 + 13 → `total`=0xFFF (saturated), `overflow`=1.
- **Mid-run events:**
  - `start` pulsed during COLLECT → ignored.
  - `reset_n` asserted during SEND_LO → `tx_valid`=0 immediately (asynchronous).
  - After release → IDLE, and a fresh run with 200×1 yields `total`=200 (bytes 0x00, 0xC8).

Source files
------------

// File: rtl/factory_press_accumulator.sv
// Sums per-machine minimum press counts from the solver cores and ships the
// saturated total to the SPI transmit path as two bytes, MSB first.
//
// state   | meaning
// IDLE    | waiting for start
// COLLECT | round-robin accept of core results until MACHINE_COUNT summed
// SEND_HI | offering total[15:8] to the SPI transmit path
// SEND_LO | offering total[7:0] to the SPI transmit path
// DONE    | both bytes sent, total held, waiting for a new start
module factory_press_accumulator #(
  parameter int CORE_COUNT    = 2,
  parameter int MACHINE_COUNT = 200,
  parameter int PRESS_WIDTH   = 4,
  parameter int TOTAL_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [CORE_COUNT-1:0]             core_result_valid,
  input  logic [CORE_COUNT*PRESS_WIDTH-1:0] core_result_presses,
  output logic [CORE_COUNT-1:0]             core_result_ready,
  output logic [7:0]                        tx_byte,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  output logic [TOTAL_WIDTH-1:0]            total,
  output logic                              overflow,
  output logic                              done
);

  localparam int PTR_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam int CNT_W = $clog2(MACHINE_COUNT + 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SEND_HI,
    SEND_LO,
    DONE
  } state_t;

  state_t                 state;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       grant_next;
  logic                   grant_found;
  logic [PRESS_WIDTH-1:0] grant_press;
  logic [CNT_W-1:0]       result_cnt;
  logic [TOTAL_WIDTH:0]   sum_wide;
  logic [TOTAL_WIDTH-1:0] sum_sat;
  logic                   accept;

  // Scan cores starting at the pointer; the first valid one wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_next  = '0;
    grant_press = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      idx = (int'(rr_ptr) + k) % CORE_COUNT;
      if (!grant_found && core_result_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
        grant_next  = PTR_W'((idx + 1) % CORE_COUNT);
        grant_press = core_result_presses[idx*PRESS_WIDTH +: PRESS_WIDTH];
      end
    end
  end

  assign accept = (state == COLLECT) && grant_found;

  always_comb begin
    core_result_ready = '0;
    if (accept) core_result_ready[grant_idx] = 1'b1;
  end

  assign sum_wide = {1'b0, total} + (TOTAL_WIDTH+1)'(grant_press);
  assign sum_sat  = sum_wide[TOTAL_WIDTH] ? '1 : sum_wide[TOTAL_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      total      <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      tx_valid   <= 1'b0;
      tx_byte    <= 8'h00;
      result_cnt <= '0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            total      <= '0;
            overflow   <= 1'b0;
            result_cnt <= '0;
            rr_ptr     <= '0;
            done       <= 1'b0;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (grant_found) begin
            total      <= sum_sat;
            result_cnt <= result_cnt + 1'b1;
            rr_ptr     <= grant_next;
            if (sum_wide[TOTAL_WIDTH]) overflow <= 1'b1;
            // Load the high byte from the post-add value so it is ready the
            // cycle SEND_HI is entered.
            if (result_cnt == CNT_W'(MACHINE_COUNT - 1)) begin
              state    <= SEND_HI;
              tx_valid <= 1'b1;
              tx_byte  <= 8'(sum_sat >> 8);
            end
          end
        end
        SEND_HI: begin
          if (tx_ready) begin
            tx_byte <= total[7:0];
            state   <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_factory_press_accumulator.sv
// Directed sequence with randomized core traffic for factory_press_accumulator;
// three builds share the stimulus, one selected at a time.
module tb_factory_press_accumulator;
  localparam int CC = 2;
  localparam int PW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, start, tx_ready;
  logic [CC-1:0]     valid;
  logic [CC*PW-1:0]  presses;
  int                sel;

  logic [CC-1:0] rdy_a, rdy_b, rdy_c;
  logic [7:0]    byte_a, byte_b, byte_c;
  logic          txv_a, txv_b, txv_c, ovf_a, ovf_b, ovf_c, done_a, done_b, done_c;
  logic [15:0]   tot_a, tot_b;
  logic [11:0]   tot_c;

  factory_press_accumulator #(.CORE_COUNT(CC), .MACHINE_COUNT(4), .PRESS_WIDTH(PW), .TOTAL_WIDTH(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start && sel == 0),
    .core_result_valid(sel == 0 ? valid : {CC{1'b0}}), .core_result_presses(presses),
    .core_result_ready(rdy_a), .tx_byte(byte_a), .tx_valid(txv_a), .tx_ready(tx_ready),
    .total(tot_a), .overflow(ovf_a), .done(done_a));

  factory_press_accumulator #(.CORE_COUNT(CC), .MACHINE_COUNT(200), .PRESS_WIDTH(PW), .TOTAL_WIDTH(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start && sel == 1),
    .core_result_valid(sel == 1 ? valid : {CC{1'b0}}), .core_result_presses(presses),
    .core_result_ready(rdy_b), .tx_byte(byte_b), .tx_valid(txv_b), .tx_ready(tx_ready),
    .total(tot_b), .overflow(ovf_b), .done(done_b));

  factory_press_accumulator #(.CORE_COUNT(CC), .MACHINE_COUNT(400), .PRESS_WIDTH(PW), .TOTAL_WIDTH(12)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start && sel == 2),
    .core_result_valid(sel == 2 ? valid : {CC{1'b0}}), .core_result_presses(presses),
    .core_result_ready(rdy_c), .tx_byte(byte_c), .tx_valid(txv_c), .tx_ready(tx_ready),
    .total(tot_c), .overflow(ovf_c), .done(done_c));

  logic [CC-1:0] ready_m;
  logic [7:0]    tx_byte_m;
  logic          tx_valid_m, ovf_m, done_m;
  logic [15:0]   total_m;

  assign ready_m    = (sel == 0) ? rdy_a  : (sel == 1) ? rdy_b  : rdy_c;
  assign tx_byte_m  = (sel == 0) ? byte_a : (sel == 1) ? byte_b : byte_c;
  assign tx_valid_m = (sel == 0) ? txv_a  : (sel == 1) ? txv_b  : txv_c;
  assign ovf_m      = (sel == 0) ? ovf_a  : (sel == 1) ? ovf_b  : ovf_c;
  assign done_m     = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
  assign total_m    = (sel == 0) ? tot_a  : (sel == 1) ? tot_b  : {4'h0, tot_c};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rx_q[$];
  always @(negedge clk) if (reset_n && tx_valid_m && tx_ready) rx_q.push_back(tx_byte_m);

  // Reference model: per-core result lists, exact running sum, accepted count.
  longint raw;
  int     mcnt, mptr, start_cyc;
  int     dat[CC][1024];
  int     hd[CC], tl[CC];
  int     grants[$];
  int     total_n = 0;
  int     bad_n = 0;

  function automatic longint maxv();
    return (sel == 2) ? 64'd4095 : 64'd65535;
  endfunction

  function automatic longint sat_val();
    return (raw > maxv()) ? maxv() : raw;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int v);
    dat[c][tl[c]] = v;
    tl[c]++;
  endtask

  task automatic push_rand(input int n, input int v);
    for (int i = 0; i < n; i++) push($urandom_range(CC-1), (v < 0) ? $urandom_range(13) : v);
  endtask

  task automatic model_clear();
    raw = 0; mcnt = 0; mptr = 0;
    for (int c = 0; c < CC; c++) begin hd[c] = 0; tl[c] = 0; end
    valid = '0; presses = '0;
    grants.delete();
    rx_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // Act as the cores: offer queued results (optionally with random idle gaps),
  // hold each offer until accepted, and follow the round-robin grant rule.
  task automatic feed(input int target, input bit gaps);
    int budget;
    int g;
    logic [CC-1:0] er;
    budget = 0;
    while (mcnt < target && budget < 5000) begin
      for (int c = 0; c < CC; c++)
        if (!valid[c] && hd[c] < tl[c] && (!gaps || $urandom_range(2) != 0)) begin
          valid[c] = 1'b1;
          presses[c*PW +: PW] = PW'(dat[c][hd[c]]);
        end
      @(negedge clk);
      g = -1;
      for (int k = 0; k < CC; k++)
        if (g < 0 && valid[(mptr + k) % CC]) g = (mptr + k) % CC;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("ready", 32'(ready_m), 32'(er));
      chk("running_total", 32'(total_m), 32'(sat_val()));
      if (g >= 0) begin
        raw += dat[g][hd[g]];
        hd[g]++;
        mcnt++;
        mptr = (g + 1) % CC;
        grants.push_back(g);
      end
      tick();
      if (g >= 0) valid[g] = 1'b0;
      budget++;
    end
    chk("feed_budget", 32'(budget < 5000), 32'd1);
  endtask

  task automatic finish_run(input string tag);
    int n;
    n = 0;
    while (!done_m && n < 40) begin tick(); n++; end
    chk({tag, "_done"}, 32'(done_m), 32'd1);
    chk({tag, "_txv_low"}, 32'(tx_valid_m), 32'd0);
    chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'd2);
    if (rx_q.size() >= 1) chk({tag, "_hi_byte"}, 32'(rx_q[0]), 32'((sat_val() >> 8) & 255));
    if (rx_q.size() >= 2) chk({tag, "_lo_byte"}, 32'(rx_q[1]), 32'(sat_val() & 255));
    chk({tag, "_total"}, 32'(total_m), 32'(sat_val()));
    chk({tag, "_overflow"}, 32'(ovf_m), 32'(raw > maxv()));
    rx_q.delete();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; tx_ready = 1'b1; sel = 0;
    valid = '1; presses = '1;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_total", 32'(total_m), 32'd0);
      chk("rst_overflow", 32'(ovf_m), 32'd0);
      chk("rst_done", 32'(done_m), 32'd0);
      chk("rst_txv", 32'(tx_valid_m), 32'd0);
      chk("rst_txbyte", 32'(tx_byte_m), 32'd0);
      chk("rst_ready", 32'(ready_m), 32'd0);
    end
    valid = '0; presses = '0; sel = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();

    // single core, MACHINE_COUNT=4: 3+5+7+1
    model_clear();
    push(0, 3); push(0, 5); push(0, 7); push(0, 1);
    pulse_start();
    chk("start_total", 32'(total_m), 32'd0);
    feed(4, 1'b0);
    begin
      int n;
      n = 0;
      while (!done_m && n < 20) begin tick(); n++; end
    end
    // start driven in cycle 0 and sampled at the edge ending it; done follows M+2 edges later
    chk("single_latency", 32'(cyc - start_cyc), 32'd6);
    chk("single_total16", 32'(total_m), 32'd16);
    finish_run("single");

    // round-robin fairness with both cores always valid
    sel = 1;
    model_clear();
    push(0, 2); push(0, 2); push(0, 2);
    push(1, 9); push(1, 9); push(1, 9);
    pulse_start();
    feed(6, 1'b0);
    for (int k = 0; k < 6; k++) chk("rr_grant", 32'(grants[k]), 32'(k % 2));
    chk("rr_total33", 32'(total_m), 32'd33);

    // start mid-collection must not restart the run
    pulse_start();
    tick();
    chk("midstart_total", 32'(total_m), 32'd33);

    // random remainder, then transmit backpressure
    push_rand(194, -1);
    tx_ready = 1'b0;
    feed(200, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_txv", 32'(tx_valid_m), 32'd1);
      chk("bp_hi_stable", 32'(tx_byte_m), 32'((sat_val() >> 8) & 255));
      tick();
    end
    tx_ready = 1'b1;
    tick();
    chk("bp_lo_next", 32'(tx_byte_m), 32'(sat_val() & 255));
    chk("bp_lo_txv", 32'(tx_valid_m), 32'd1);
    finish_run("bp");

    // 200 results of 13, restarted from DONE
    model_clear();
    push_rand(200, 13);
    pulse_start();
    chk("restart_done_clr", 32'(done_m), 32'd0);
    chk("restart_total_clr", 32'(total_m), 32'd0);
    feed(200, 1'b1);
    chk("r13_total2600", 32'(total_m), 32'd2600);
    finish_run("r13");

    // asynchronous reset while the low byte is pending
    model_clear();
    push_rand(200, 1);
    pulse_start();
    tx_ready = 1'b0;
    feed(200, 1'b1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    tick();
    chk("sendlo_txv", 32'(tx_valid_m), 32'd1);
    chk("sendlo_byte", 32'(tx_byte_m), 32'h0C8);
    reset_n = 1'b0;
    #1;
    chk("async_txv", 32'(tx_valid_m), 32'd0);
    chk("async_total", 32'(total_m), 32'd0);
    chk("async_done", 32'(done_m), 32'd0);
    tick();
    reset_n = 1'b1;
    valid = '1;
    #1;
    chk("idle_ready", 32'(ready_m), 32'd0);
    tick();
    chk("idle_total", 32'(total_m), 32'd0);
    model_clear();
    push_rand(200, 1);
    tx_ready = 1'b1;
    pulse_start();
    feed(200, 1'b1);
    chk("fresh_total200", 32'(total_m), 32'd200);
    finish_run("fresh");

    // 12-bit build: 4090 + 13 saturates at 0xFFF
    sel = 2;
    model_clear();
    push_rand(314, 13);
    push($urandom_range(CC-1), 8);
    pulse_start();
    feed(315, 1'b1);
    chk("pre_sat_total", 32'(total_m), 32'd4090);
    chk("pre_sat_ovf", 32'(ovf_m), 32'd0);
    push($urandom_range(CC-1), 13);
    feed(316, 1'b1);
    chk("sat_total", 32'(total_m), 32'hFFF);
    chk("sat_ovf", 32'(ovf_m), 32'd1);
    push_rand(84, -1);
    feed(400, 1'b1);
    finish_run("sat");

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
